// File: rtl/miu_pkg.sv
// Shared types for the MIU CPU-side bus arbiter: port indices, arbiter state, port IDs.
// Bus field widths come from the PKT_* macros; defaults apply when they are not already defined.
`ifndef PKT_ADDR
`define PKT_ADDR 32
`endif
`ifndef PKT_DATA
`define PKT_DATA 32
`endif
`ifndef PKT_SIZE
`define PKT_SIZE 2
`endif

package miu_pkg;

  localparam int unsigned PORT_W = 4;

  typedef logic [PORT_W-1:0] port_idx_t;

  localparam port_idx_t PORT_IFETCH = 4'd0;
  localparam port_idx_t PORT_LSU    = 4'd1;

  typedef struct packed {
    logic      lock;
    port_idx_t lock_owner;
    port_idx_t rr_ptr;
    logic      dp_valid;
    port_idx_t dp_owner;
  } arb_state_t;

  function automatic port_idx_t next_port(input port_idx_t p, input int unsigned n);
    return (32'(p) == n - 1) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/miu_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo N.
module rr_pick
  import miu_pkg::*;
#(
  parameter int unsigned N  = 2,
  parameter int unsigned PW = 1
) (
  input  logic [N-1:0]  req,
  input  port_idx_t     ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx
);

  logic          found;
  logic [PW-1:0] j;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = '0;
    for (int unsigned off = 0; off < N; off++) begin
      j = PW'((32'(ptr) + off) % N);
      if (!found && req[j]) begin
        grant[j] = 1'b1;
        idx      = j;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/miu_bus_arbiter.sv
// Round-robin arbiter sharing the pipelined MIU bus among N_PORTS requesters,
// holding the grant through stalled address phases and routing data-phase completions.
`ifndef PKT_ADDR
`define PKT_ADDR 32
`endif
`ifndef PKT_DATA
`define PKT_DATA 32
`endif
`ifndef PKT_SIZE
`define PKT_SIZE 2
`endif

module miu_bus_arbiter
  import miu_pkg::*;
#(
  parameter int unsigned N_PORTS = 2
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [N_PORTS*`PKT_ADDR-1:0]   req_addr,
  input  logic [N_PORTS-1:0]             req_valid,
  input  logic [N_PORTS*`PKT_DATA-1:0]   req_wdata,
  input  logic [N_PORTS*`PKT_SIZE-1:0]   req_wsize,
  input  logic [N_PORTS-1:0]             req_write,
  output logic [N_PORTS-1:0]             req_ready,
  output logic [N_PORTS-1:0]             rsp_valid,
  output logic [`PKT_DATA-1:0]           rsp_rdata,
  output logic [`PKT_ADDR-1:0]           bus_addr,
  output logic                           bus_valid,
  output logic [`PKT_DATA-1:0]           bus_wdata,
  output logic [`PKT_SIZE-1:0]           bus_wsize,
  output logic                           bus_write,
  input  logic [`PKT_DATA-1:0]           bus_rdata,
  input  logic                           bus_ready
);

  localparam int unsigned PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  arb_state_t         state_q, state_d;
  logic [N_PORTS-1:0] pick_grant;
  logic [PW-1:0]      pick_idx;
  logic [N_PORTS-1:0] grant;
  port_idx_t          owner;
  logic               accept;
  logic               stall;

  rr_pick #(
    .N  (N_PORTS),
    .PW (PW)
  ) u_pick (
    .req   (req_valid),
    .ptr   (state_q.rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  always_comb begin
    grant = pick_grant;
    owner = port_idx_t'(pick_idx);
    if (state_q.lock) begin
      owner = state_q.lock_owner;
      for (int unsigned i = 0; i < N_PORTS; i++) begin
        grant[i] = (state_q.lock_owner == port_idx_t'(i));
      end
    end
  end

  assign bus_valid = |req_valid;
  assign accept    = bus_valid & bus_ready;
  assign stall     = bus_valid & ~bus_ready;
  assign req_ready = grant & {N_PORTS{bus_ready}};
  assign rsp_rdata = bus_rdata;

  always_comb begin
    bus_addr  = '0;
    bus_wdata = '0;
    bus_wsize = '0;
    bus_write = 1'b0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      if (bus_valid && grant[i]) begin
        bus_addr  = req_addr[i*`PKT_ADDR +: `PKT_ADDR];
        bus_wdata = req_wdata[i*`PKT_DATA +: `PKT_DATA];
        bus_wsize = req_wsize[i*`PKT_SIZE +: `PKT_SIZE];
        bus_write = req_write[i];
      end
    end
  end

  // Gated by reset_n so a data phase being dropped by reset never signals completion.
  always_comb begin
    rsp_valid = '0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      rsp_valid[i] = reset_n & state_q.dp_valid & bus_ready &
                     (state_q.dp_owner == port_idx_t'(i));
    end
  end

  // Accept takes priority over completion so back-to-back transfers keep dp_valid set.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d.lock     = 1'b0;
      state_d.rr_ptr   = next_port(owner, N_PORTS);
      state_d.dp_valid = 1'b1;
      state_d.dp_owner = owner;
    end else if (stall) begin
      state_d.lock       = 1'b1;
      state_d.lock_owner = owner;
    end else if (bus_ready) begin
      state_d.dp_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_miu_bus_arbiter.sv
// Self-checking bench for miu_bus_arbiter: vector table, directed corner sequences,
// and randomized traffic against a transaction-level reference model.
`ifndef PKT_ADDR
`define PKT_ADDR 32
`endif
`ifndef PKT_DATA
`define PKT_DATA 32
`endif
`ifndef PKT_SIZE
`define PKT_SIZE 2
`endif

module tb_miu_bus_arbiter;
  import miu_pkg::*;

  localparam int unsigned N  = 2;
  localparam int unsigned AW = `PKT_ADDR;
  localparam int unsigned DW = `PKT_DATA;
  localparam int unsigned SW = `PKT_SIZE;

  logic              clk;
  logic              reset_n;
  logic [N*AW-1:0]   req_addr;
  logic [N-1:0]      req_valid;
  logic [N*DW-1:0]   req_wdata;
  logic [N*SW-1:0]   req_wsize;
  logic [N-1:0]      req_write;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic [AW-1:0]     bus_addr;
  logic              bus_valid;
  logic [DW-1:0]     bus_wdata;
  logic [SW-1:0]     bus_wsize;
  logic              bus_write;
  logic [DW-1:0]     bus_rdata;
  logic              bus_ready;

  logic          p_valid [N];
  logic [AW-1:0] p_addr  [N];
  logic [DW-1:0] p_wdata [N];
  logic [SW-1:0] p_wsize [N];
  logic          p_write [N];

  int errors = 0;
  int checks = 0;

  miu_bus_arbiter #(.N_PORTS(N)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_addr  (req_addr),
    .req_valid (req_valid),
    .req_wdata (req_wdata),
    .req_wsize (req_wsize),
    .req_write (req_write),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .bus_addr  (bus_addr),
    .bus_valid (bus_valid),
    .bus_wdata (bus_wdata),
    .bus_wsize (bus_wsize),
    .bus_write (bus_write),
    .bus_rdata (bus_rdata),
    .bus_ready (bus_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_valid[i]            = p_valid[i];
      req_addr[i*AW +: AW]    = p_addr[i];
      req_wdata[i*DW +: DW]   = p_wdata[i];
      req_wsize[i*SW +: SW]   = p_wsize[i];
      req_write[i]            = p_write[i];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_ports();
    for (int i = 0; i < N; i++) begin
      p_valid[i] = 1'b0;
      p_addr[i]  = '0;
      p_wdata[i] = '0;
      p_wsize[i] = '0;
      p_write[i] = 1'b0;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    bus_ready = 1'b1;
    bus_rdata = '0;
    clear_ports();
    next_cycle();
    @(negedge clk);
    chk("reset_rsp_valid", rsp_valid, '0);
    chk("reset_bus_valid", bus_valid, 0);
    chk("reset_req_ready", req_ready, '0);
    next_cycle();
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic [1:0]  valid;
    logic        ready;
    logic [1:0]  exp_rr;
    logic [1:0]  exp_rsp;
    logic        exp_bv;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t tbl [14];

  // Reference model: pending stalled owner, data-phase owner and pointer as plain ints (-1 = none).
  int m_ptr, m_lock, m_dp;

  function automatic int model_owner();
    if (m_lock >= 0) return m_lock;
    for (int k = 0; k < N; k++) begin
      int p;
      p = (m_ptr + k) % N;
      if (p_valid[p]) return p;
    end
    return -1;
  endfunction

  initial begin
    reset_n = 1'b0;
    clear_ports();
    bus_ready = 1'b0;
    bus_rdata = '0;

    // Contention, stalled address phase with a late competing request, then idle.
    tbl[0]  = '{2'b11, 1'b1, 2'b01, 2'b00, 1'b1, 32'h100};
    tbl[1]  = '{2'b11, 1'b1, 2'b10, 2'b01, 1'b1, 32'h200};
    tbl[2]  = '{2'b11, 1'b1, 2'b01, 2'b10, 1'b1, 32'h100};
    tbl[3]  = '{2'b11, 1'b1, 2'b10, 2'b01, 1'b1, 32'h200};
    tbl[4]  = '{2'b10, 1'b0, 2'b00, 2'b00, 1'b1, 32'h200};
    tbl[5]  = '{2'b11, 1'b0, 2'b00, 2'b00, 1'b1, 32'h200};
    tbl[6]  = '{2'b11, 1'b0, 2'b00, 2'b00, 1'b1, 32'h200};
    tbl[7]  = '{2'b11, 1'b1, 2'b10, 2'b10, 1'b1, 32'h200};
    tbl[8]  = '{2'b01, 1'b1, 2'b01, 2'b10, 1'b1, 32'h100};
    tbl[9]  = '{2'b00, 1'b1, 2'b00, 2'b01, 1'b0, 32'h0};
    tbl[10] = '{2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 32'h0};
    tbl[11] = '{2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 32'h0};
    tbl[12] = '{2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 32'h0};
    tbl[13] = '{2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 32'h0};

    // Single read on port 0.
    do_reset();
    p_addr[0]  = 32'h100;
    p_valid[0] = 1'b1;
    bus_ready  = 1'b1;
    @(negedge clk);
    chk("single_req_ready", req_ready, 2'b01);
    chk("single_bus_addr", bus_addr, 32'h100);
    chk("single_rsp_early", rsp_valid, 2'b00);
    next_cycle();
    p_valid[0] = 1'b0;
    bus_rdata  = 32'hDEAD;
    @(negedge clk);
    chk("single_rsp_valid", rsp_valid, 2'b01);
    chk("single_rsp_rdata", rsp_rdata, 32'hDEAD);
    next_cycle();

    // Vector table.
    do_reset();
    p_addr[0] = 32'h100;
    p_addr[1] = 32'h200;
    for (int k = 0; k < 14; k++) begin
      p_valid[0] = tbl[k].valid[0];
      p_valid[1] = tbl[k].valid[1];
      bus_ready  = tbl[k].ready;
      @(negedge clk);
      chk($sformatf("tbl%0d_req_ready", k), req_ready, tbl[k].exp_rr);
      chk($sformatf("tbl%0d_rsp_valid", k), rsp_valid, tbl[k].exp_rsp);
      chk($sformatf("tbl%0d_bus_valid", k), bus_valid, tbl[k].exp_bv);
      chk($sformatf("tbl%0d_bus_addr", k), bus_addr, tbl[k].exp_addr);
      next_cycle();
    end

    // Stalled data phase released together with the next accept.
    do_reset();
    p_addr[0]  = 32'h300;
    p_valid[0] = 1'b1;
    p_addr[1]  = 32'h304;
    p_wdata[1] = 32'h55;
    p_wsize[1] = '0;
    p_write[1] = 1'b1;
    p_valid[1] = 1'b1;
    bus_ready  = 1'b1;
    @(negedge clk);
    chk("dstall_c1_req_ready", req_ready, 2'b01);
    next_cycle();
    p_valid[0] = 1'b0;
    bus_ready  = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("dstall_hold_req_ready", req_ready, 2'b00);
      chk("dstall_hold_rsp_valid", rsp_valid, 2'b00);
      chk("dstall_bus_write", bus_write, 1);
      chk("dstall_bus_wdata", bus_wdata, 32'h55);
      chk("dstall_bus_wsize", bus_wsize, 0);
      chk("dstall_bus_addr", bus_addr, 32'h304);
      next_cycle();
    end
    bus_ready = 1'b1;
    @(negedge clk);
    chk("dstall_rel_req_ready", req_ready, 2'b10);
    chk("dstall_rel_rsp_valid", rsp_valid, 2'b01);
    next_cycle();
    p_valid[1] = 1'b0;
    @(negedge clk);
    chk("dstall_last_rsp_valid", rsp_valid, 2'b10);
    chk("dstall_last_req_ready", req_ready, 2'b00);
    next_cycle();

    // Reset during an outstanding data phase.
    do_reset();
    p_addr[0]  = 32'h400;
    p_addr[1]  = 32'h500;
    p_valid[0] = 1'b1;
    bus_ready  = 1'b1;
    @(negedge clk);
    chk("rst_mid_accept", req_ready, 2'b01);
    next_cycle();
    p_valid[0] = 1'b0;
    reset_n    = 1'b0;
    @(negedge clk);
    chk("rst_mid_no_rsp", rsp_valid, 2'b00);
    next_cycle();
    reset_n    = 1'b1;
    p_valid[0] = 1'b1;
    p_valid[1] = 1'b1;
    @(negedge clk);
    chk("rst_after_no_rsp", rsp_valid, 2'b00);
    chk("rst_after_grant0", req_ready, 2'b01);
    chk("rst_after_addr", bus_addr, 32'h400);
    next_cycle();
    p_valid[0] = 1'b0;
    p_valid[1] = 1'b0;
    @(negedge clk);
    chk("rst_after_rsp", rsp_valid, 2'b01);
    next_cycle();

    // Randomized traffic against the reference model.
    do_reset();
    m_ptr  = 0;
    m_lock = -1;
    m_dp   = -1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      int o;
      logic [1:0] exp_rr, exp_rsp;
      bus_ready = ($urandom_range(0, 9) < 7);
      bus_rdata = $urandom;
      @(negedge clk);
      o       = model_owner();
      exp_rr  = (o >= 0 && bus_ready) ? 2'(1 << o) : 2'b00;
      exp_rsp = (m_dp >= 0 && bus_ready) ? 2'(1 << m_dp) : 2'b00;
      chk("rnd_req_ready", req_ready, exp_rr);
      chk("rnd_rsp_valid", rsp_valid, exp_rsp);
      chk("rnd_bus_valid", bus_valid, (o >= 0) ? 1 : 0);
      if (o >= 0) begin
        chk("rnd_bus_addr", bus_addr, p_addr[o]);
        chk("rnd_bus_wdata", bus_wdata, p_wdata[o]);
        chk("rnd_bus_wsize", bus_wsize, p_wsize[o]);
        chk("rnd_bus_write", bus_write, p_write[o]);
      end else begin
        chk("rnd_idle_addr", bus_addr, 0);
      end
      if (exp_rsp != 2'b00) chk("rnd_rsp_rdata", rsp_rdata, bus_rdata);
      if (bus_ready) begin
        m_dp   = o;
        m_lock = -1;
        if (o >= 0) m_ptr = (o + 1) % N;
      end else if (o >= 0) begin
        m_lock = o;
      end
      next_cycle();
      for (int p = 0; p < N; p++) begin
        logic raise;
        raise = 1'b0;
        if (p_valid[p] && bus_ready && o == p) begin
          p_valid[p] = 1'b0;
          raise = ($urandom_range(0, 1) == 1);
        end else if (!p_valid[p]) begin
          raise = ($urandom_range(0, 9) < 4);
        end
        if (raise) begin
          p_valid[p] = 1'b1;
          p_addr[p]  = $urandom;
          p_wdata[p] = $urandom;
          p_wsize[p] = SW'($urandom_range(0, (1 << SW) - 1));
          p_write[p] = 1'($urandom_range(0, 1));
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/miu_bus_arbiter.md
Name: miu_bus_arbiter

Overview:
- Shares the single MIU CPU-side bus between N_PORTS requesters, e.g. port 0 = instruction fetch and port 1 = load/store unit.
- The bus is the pipelined bus_addr/bus_valid/bus_ready interface in front of the AHB-Lite master: address phase, then data phase; HWDATA is registered on accept.
- Arbitrates address phases round-robin, holds the grant stable across stalled address phases, and tracks which port owns the outstanding data phase so read data and completions route back correctly.

Parameters:
- N_PORTS, 2, number of requesters (≥2).
- PW, $clog2(N_PORTS), port index width (derived, localparam).

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous reset, active-low
- req_addr  in  N_PORTS×`PKT_ADDR  per-port address
- req_valid  in  N_PORTS  per-port request
- req_wdata  in  N_PORTS×`PKT_DATA  per-port write data
- req_wsize  in  N_PORTS×`PKT_SIZE  per-port write size
- req_write  in  N_PORTS  per-port write strobe
- req_ready  out  N_PORTS  address phase accepted this cycle
- rsp_valid  out  N_PORTS  data phase complete this cycle (reads and writes)
- rsp_rdata  out  `PKT_DATA  read data, broadcast, qualified by rsp_valid
- bus_addr  out  `PKT_ADDR  to MIU master
- bus_valid  out  1  to MIU master
- bus_wdata  out  `PKT_DATA  to MIU master
- bus_wsize  out  `PKT_SIZE  to MIU master
- bus_write  out  1  to MIU master
- bus_rdata  in  `PKT_DATA  from MIU master
- bus_ready  in  1  from MIU master (HREADY)

Behaviour:
- Requester rule: once req_valid[i] is asserted, it and all req_* fields stay stable until req_ready[i].
- Grant selection, when not locked: first valid port starting at rr_ptr, wrapping modulo N_PORTS. With no valid port, bus_valid=0 and the other bus_* outputs are don't-care (driven 0).
- Mux: bus_* = the granted port's req_*. bus_valid = |req_valid.
- req_ready[i] = grant[i] & bus_ready. This is combinational and reaches only the granted port.
- Lock:
  - If bus_valid & ~bus_ready, lock=1 and lock_owner = the granted port.
  - While locked, the grant is forced to lock_owner regardless of other requests.
  - Lock clears on the accept cycle.
- Round-robin: on accept, rr_ptr <= owner+1, wrapping from N_PORTS-1 to 0.
- Data-phase tracking:
  - On accept, dp_valid<=1 and dp_owner<=owner.
  - Else if dp_valid & bus_ready, dp_valid<=0.
  - An accept and a completion in the same cycle leave dp_valid=1 with the new owner (back-to-back pipelining; no bubble required).
- rsp_valid[i] = dp_valid & (dp_owner==i) & bus_ready. rsp_rdata = bus_rdata.
- Stalls: bus_ready=0 stalls the address and data phases together; no state changes except lock set.
- Reset values (reset_n=0 at clk edge): rr_ptr=0, lock=0, lock_owner=0, dp_valid=0, dp_owner=0.
  - Outputs after reset: req_ready follows the combinational rule, rsp_valid=0.
  - Reset mid-transfer drops any outstanding data phase; no rsp_valid is issued for it.
- Latency:
  - Grant to req_ready is 0 cycles when bus_ready=1.
  - rsp_valid comes ≥1 cycle after req_ready.
  - Back-to-back sustained throughput is 1 transfer/cycle.
- A port may issue a new request in the same cycle its previous rsp_valid fires.

Decomposition:
- Shared package miu_pkg:
  - port index type
  - arbiter state struct (lock, lock_owner, rr_ptr, dp_valid, dp_owner)
  - port ID constants PORT_IFETCH=0, PORT_LSU=1
- Bus field widths stay in the existing `PKT_* macros.
- One sub-module, rr_pick: combinational round-robin priority picker. Inputs: request vector and pointer. Output: one-hot grant plus index.

Test Plan:
- Single read, port 0: req_valid=01, addr=0x100, bus_ready=1 → req_ready[0] same cycle. Next cycle bus_rdata=0xDEAD → rsp_valid=01, rsp_rdata=0xDEAD.
- Contention: both ports valid continuously, bus_ready=1 from reset → grants alternate 0,1,0,1. rsp_valid follows one cycle later with the same order.
- Stalled address phase: port 1 granted, bus_ready=0 for 3 cycles, port 0 raises valid during the stall → grant stays on port 1, bus_addr unchanged. Port 1 is accepted when bus_ready=1, then port 0 is granted next.
- Stalled data phase with pipelined accept: port 0 read accepted, port 1 write (wdata=0x55, wsize=byte) waiting, bus_ready=0 for 2 cycles → on the release cycle rsp_valid[0]=1 and req_ready[1]=1 together, dp_owner=1. The following cycle gives rsp_valid[1].
- Reset mid-operation: accept port 0, then assert reset_n=0 during the data phase → no rsp_valid. After release the first grant goes to port 0 (rr_ptr=0).
- Idle: req_valid=00 for 5 cycles → bus_valid=0, req_ready=00, rsp_valid=00.
